note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Downstream stage of the song sequencer.
- Accepts one note (pitch index + duration in beats) per `new_note` pulse.
- Looks up the pitch step size in a frequency ROM and runs a phase accumulator at the audio sample rate for the note's duration.
- Presents `phase` to the sine/sample stage and holds `note_done` high whenever it can accept the next note.

Parameters:
- NOTE_W, 6, width of pitch index (0 = rest, 1 = A0 ... 63)
- DUR_W, 6, width of duration in beats (1 beat = 1/48 s)
- STEP_W, 20, width of frequency step-size word
- PHASE_W, 22, width of phase accumulator

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  1 = run; 0 = pause (freeze counters, silence output)
- note  in  NOTE_W  pitch index, sampled when new_note=1
- duration  in  DUR_W  note length in beats, sampled when new_note=1
- new_note  in  1  one-cycle load strobe from sequencer
- beat  in  1  one-cycle strobe at 48 Hz
- sample_tick  in  1  one-cycle strobe at 48 kHz
- note_done  out  1  level; 1 = idle, ready for next note
- active  out  1  1 while a note's step is applied (PLAY state)
- step_size  out  STEP_W  current step (0 when idle/rest/paused)
- phase  out  PHASE_W  phase accumulator to sine stage

Behaviour:
- Reset values: `note_done` = 1, `active` = 0, `step_size` = 0, `phase` = 0. State = IDLE; note/duration registers = 0.
- All outputs are registered. ROM read latency is 1 cycle (synchronous).
- States:
  - IDLE: `note_done` = 1. `new_note` sampled at edge E0 latches note and duration, sets `note_done` to 0, and moves to FETCH.
  - FETCH: ROM address = latched note. At E1 the ROM data becomes valid; move to LOAD.
  - LOAD: at E2, `step_size` <= ROM data (0 if note = 0), remaining <= duration, `active` <= 1, move to PLAY. `step_size` is therefore visible 2 cycles after `new_note` is sampled.
  - PLAY: each `beat` with `play` = 1 decrements remaining. The beat that takes remaining from 1 to 0 does the following at the same edge:
    - state <= IDLE
    - `note_done` <= 1
    - `active` <= 0
    - `step_size` <= 0
- A duration-d note therefore occupies exactly d beats of PLAY.
- `note_done` falls at the edge sampling `new_note`. The sequencer's 1-cycle post-pulse wait therefore sees it low before re-polling.
- Phase accumulator: on `sample_tick` with `play` = 1, phase <= phase + zero-extended step_size, modulo 2^PHASE_W (wraps, no saturation). Phase is not cleared between notes, only by reset.
- Pause (`play` = 0):
  - beats and sample_ticks are ignored
  - remaining and phase hold
  - `step_size` output forced to 0
  - state and `note_done` are held
  - resuming continues from the same remaining count
- Duration 0: treated as done. In LOAD, go straight to IDLE, raise `note_done`, never assert `active`.
- `new_note` while in FETCH/LOAD/PLAY: abort the current note, latch the new one, go to FETCH (`note_done` stays 0, `active` <= 0, `step_size` <= 0).
- `new_note` and `beat` in the same cycle: `new_note` wins; that beat is not counted.
- Beats arriving in FETCH/LOAD are dropped. This is acceptable at 48 Hz vs a 2-cycle window.
- Reset mid-note: immediate return to reset values.

Optional Feature:
- NOTE_GAP_EN
  - Defined: for notes with duration >= 2, during the final beat (remaining = 1) `step_size` output = 0 while `active` stays 1. This gives audible articulation between repeated pitches. The phase accumulator still advances by 0 (holds).
  - Undefined: full-length legato; `step_size` stays constant for all d beats.

Decomposition:
- Shared package `music_pkg`:
  - NOTE_W, DUR_W, STEP_W, PHASE_W
  - REST_NOTE = 0
  - BEAT_HZ = 48
  - SAMPLE_HZ = 48000
  - state encoding constants (IDLE, FETCH, LOAD, PLAY)
- Sub-module `frequency_rom`: 64 x STEP_W synchronous ROM, entry n = round(f(n)·2^PHASE_W / SAMPLE_HZ), entry 0 = 0.

Test Plan:
- Note 49 (A4), duration 3, play = 1 -> `note_done` low at E0+1. `step_size` = 38448 from E2. `note_done` high at the edge of the 3rd beat. `phase` advances by 38448 per `sample_tick`.
- Note 0 (rest), duration 2 -> `active` = 1 for 2 beats with `step_size` = 0. `phase` constant.
- Duration 0 load -> `active` never 1. `note_done` back to 1 within 3 cycles.
- Note 49, duration 4: drop `play` after beat 1, hold `play` low across 5 beats, then restore -> `step_size` 0 while paused, `phase` frozen, note ends after 3 further beats.
- `new_note` (note 10, duration 2) during PLAY of note 49 -> `step_size` = ROM[10] 2 cycles later, 2 beats counted. `new_note` with a simultaneous beat -> that beat is not counted.
- `phase` preset near 2^22−1 by running note 63 -> wraps modulo 2^22. Reset asserted mid-PLAY -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/music_pkg.sv
// Shared widths, rates and state encoding for the song sequencer / note player path.
package music_pkg;

    localparam int unsigned NOTE_W    = 6;
    localparam int unsigned DUR_W     = 6;
    localparam int unsigned STEP_W    = 20;
    localparam int unsigned PHASE_W   = 22;

    localparam int unsigned REST_NOTE = 0;
    localparam int unsigned BEAT_HZ   = 48;
    localparam int unsigned SAMPLE_HZ = 48000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } state_e;

endpackage

// File: rtl/frequency_rom.sv
// 64-entry synchronous step-size ROM: entry n = round(f(n) * 2^PHASE_W / SAMPLE_HZ),
// with f(1) = A0 = 27.5 Hz, equal temperament, entry 0 (rest) = 0.
module frequency_rom
    import music_pkg::*;
(
    input  logic              clk,
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] rd_data
);

    logic [STEP_W-1:0] data_d;
    logic [STEP_W-1:0] data_q;

    always_comb begin
        data_d = '0;
        case (addr)
            6'd1:  data_d = 20'd2403;   6'd2:  data_d = 20'd2546;   6'd3:  data_d = 20'd2697;   6'd4:  data_d = 20'd2858;
            6'd5:  data_d = 20'd3028;   6'd6:  data_d = 20'd3208;   6'd7:  data_d = 20'd3398;   6'd8:  data_d = 20'd3600;
            6'd9:  data_d = 20'd3815;   6'd10: data_d = 20'd4041;   6'd11: data_d = 20'd4282;   6'd12: data_d = 20'd4536;
            6'd13: data_d = 20'd4806;   6'd14: data_d = 20'd5092;   6'd15: data_d = 20'd5395;   6'd16: data_d = 20'd5715;
            6'd17: data_d = 20'd6055;   6'd18: data_d = 20'd6415;   6'd19: data_d = 20'd6797;   6'd20: data_d = 20'd7201;
            6'd21: data_d = 20'd7629;   6'd22: data_d = 20'd8083;   6'd23: data_d = 20'd8563;   6'd24: data_d = 20'd9072;
            6'd25: data_d = 20'd9612;   6'd26: data_d = 20'd10184;  6'd27: data_d = 20'd10789;  6'd28: data_d = 20'd11431;
            6'd29: data_d = 20'd12110;  6'd30: data_d = 20'd12830;  6'd31: data_d = 20'd13593;  6'd32: data_d = 20'd14402;
            6'd33: data_d = 20'd15258;  6'd34: data_d = 20'd16165;  6'd35: data_d = 20'd17127;  6'd36: data_d = 20'd18145;
            6'd37: data_d = 20'd19224;  6'd38: data_d = 20'd20367;  6'd39: data_d = 20'd21578;  6'd40: data_d = 20'd22861;
            6'd41: data_d = 20'd24221;  6'd42: data_d = 20'd25661;  6'd43: data_d = 20'd27187;  6'd44: data_d = 20'd28803;
            6'd45: data_d = 20'd30516;  6'd46: data_d = 20'd32331;  6'd47: data_d = 20'd34253;  6'd48: data_d = 20'd36290;
            6'd49: data_d = 20'd38448;  6'd50: data_d = 20'd40734;  6'd51: data_d = 20'd43156;  6'd52: data_d = 20'd45722;
            6'd53: data_d = 20'd48441;  6'd54: data_d = 20'd51322;  6'd55: data_d = 20'd54373;  6'd56: data_d = 20'd57607;
            6'd57: data_d = 20'd61032;  6'd58: data_d = 20'd64661;  6'd59: data_d = 20'd68506;  6'd60: data_d = 20'd72580;
            6'd61: data_d = 20'd76896;  6'd62: data_d = 20'd81468;  6'd63: data_d = 20'd86312;
            default: data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign rd_data = data_q;

endmodule

// File: rtl/note_player.sv
// Note player: latches a note, fetches its step size from frequency_rom and runs a phase
// accumulator for the note's duration in beats. Define NOTE_GAP_EN to silence the final beat.
module note_player
    import music_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic [NOTE_W-1:0]  note,
    input  logic [DUR_W-1:0]   duration,
    input  logic               new_note,
    input  logic               beat,
    input  logic               sample_tick,
    output logic               note_done,
    output logic               active,
    output logic [STEP_W-1:0]  step_size,
    output logic [PHASE_W-1:0] phase
);

`ifdef NOTE_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    state_e             state_d, state_q;
    logic [NOTE_W-1:0]  note_d, note_q;
    logic [DUR_W-1:0]   dur_d, dur_q;
    logic [DUR_W-1:0]   rem_d, rem_q;
    logic [STEP_W-1:0]  note_step_d, note_step_q;
    logic [STEP_W-1:0]  step_size_d, step_size_q;
    logic [PHASE_W-1:0] phase_d, phase_q;
    logic               done_d, done_q;
    logic               active_d, active_q;
    logic [STEP_W-1:0]  rom_data;

    frequency_rom u_rom (
        .clk     (clk),
        .addr    (note_q),
        .rd_data (rom_data)
    );

    // Articulation gap: last beat of a note lasting two or more beats is silent.
    function automatic logic in_gap(input logic [DUR_W-1:0] dur, input logic [DUR_W-1:0] rem);
        return GAP_EN && (dur >= DUR_W'(2)) && (rem == DUR_W'(1));
    endfunction

    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        dur_d       = dur_q;
        rem_d       = rem_q;
        note_step_d = note_step_q;
        step_size_d = step_size_q;
        done_d      = done_q;
        active_d    = active_q;
        phase_d     = phase_q;

        if (sample_tick && play) begin
            phase_d = phase_q + PHASE_W'(step_size_q);
        end

        // A new note always wins: abort whatever is in flight and any coincident beat.
        if (new_note) begin
            note_d      = note;
            dur_d       = duration;
            state_d     = ST_FETCH;
            done_d      = 1'b0;
            active_d    = 1'b0;
            step_size_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    step_size_d = '0;
                end
                ST_FETCH: begin
                    if (play) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (play) begin
                        if (dur_q == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            note_step_d = (note_q == NOTE_W'(REST_NOTE)) ? '0 : rom_data;
                            step_size_d = note_step_d;
                            rem_d       = dur_q;
                            active_d    = 1'b1;
                            state_d     = ST_PLAY;
                        end
                    end
                end
                ST_PLAY: begin
                    if (!play) begin
                        step_size_d = '0;
                    end else if (beat) begin
                        if (rem_q == DUR_W'(1)) begin
                            rem_d       = '0;
                            state_d     = ST_IDLE;
                            done_d      = 1'b1;
                            active_d    = 1'b0;
                            step_size_d = '0;
                        end else begin
                            rem_d       = rem_q - DUR_W'(1);
                            step_size_d = in_gap(dur_q, rem_d) ? '0 : note_step_q;
                        end
                    end else begin
                        step_size_d = in_gap(dur_q, rem_q) ? '0 : note_step_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            note_q      <= '0;
            dur_q       <= '0;
            rem_q       <= '0;
            note_step_q <= '0;
            step_size_q <= '0;
            phase_q     <= '0;
            done_q      <= 1'b1;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            rem_q       <= rem_d;
            note_step_q <= note_step_d;
            step_size_q <= step_size_d;
            phase_q     <= phase_d;
            done_q      <= done_d;
            active_q    <= active_d;
        end
    end

    assign note_done = done_q;
    assign active    = active_q;
    assign step_size = step_size_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player; expected step sizes come from an equal-temperament model.
`timescale 1ns/1ps
module tb_note_player;
    import music_pkg::*;

    logic               clk = 1'b0;
    logic               reset, play, new_note, beat, sample_tick;
    logic [NOTE_W-1:0]  note;
    logic [DUR_W-1:0]   duration;
    logic               note_done, active;
    logic [STEP_W-1:0]  step_size;
    logic [PHASE_W-1:0] phase;

    int unsigned        tests_run = 0;
    int unsigned        tests_failed = 0;
    int unsigned        sb_q[$];
    logic [PHASE_W-1:0] exp_phase;

`ifdef NOTE_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    note_player dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .note        (note),
        .duration    (duration),
        .new_note    (new_note),
        .beat        (beat),
        .sample_tick (sample_tick),
        .note_done   (note_done),
        .active      (active),
        .step_size   (step_size),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    function automatic int unsigned rom_model(input int n);
        real f;
        if (n == 0) return 0;
        f = 440.0 * $pow(2.0, (real'(n) - 49.0) / 12.0);
        return int'($rtoi(f * 4194304.0 / 48000.0 + 0.5));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_note(input int n, input int d, input string name);
        new_note = 1'b1;
        note     = NOTE_W'(n);
        duration = DUR_W'(d);
        if (d != 0) sb_q.push_back(rom_model(n));
        tick();
        new_note = 1'b0;
        beat     = 1'b0;
        tests_run++;
        if (note_done !== 1'b0 || active !== 1'b0 || step_size !== '0) begin
            tests_failed++;
            $display("FAIL %s_latch: done=%b active=%b step=%0d, need done=0 active=0 step=0",
                     name, note_done, active, step_size);
        end
    endtask

    task automatic check_load(input string name);
        int unsigned exp;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s_load: scoreboard empty", name);
        end else begin
            exp = sb_q.pop_front();
            if (step_size !== STEP_W'(exp) || active !== 1'b1 || note_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_load: step=%0d active=%b done=%b, need step=%0d active=1 done=0",
                         name, step_size, active, note_done, exp);
            end
        end
    endtask

    task automatic sample_pulse(input int unsigned step, input string name);
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        exp_phase = exp_phase + PHASE_W'(step);
        tests_run++;
        if (phase !== exp_phase) begin
            tests_failed++;
            $display("FAIL %s_phase: phase=%0d, need %0d", name, phase, exp_phase);
        end
    endtask

    task automatic beat_pulse();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic check_state(input string name, input logic exp_active, input logic exp_done,
                               input int unsigned exp_step);
        tests_run++;
        if (active !== exp_active || note_done !== exp_done || step_size !== STEP_W'(exp_step)) begin
            tests_failed++;
            $display("FAIL %s: active=%b done=%b step=%0d, need active=%b done=%b step=%0d",
                     name, active, note_done, step_size, exp_active, exp_done, exp_step);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b1; new_note = 1'b0; beat = 1'b0; sample_tick = 1'b0;
        note = '0; duration = '0;
        repeat (3) tick();
        reset = 1'b0;
        exp_phase = '0;
        check_state("reset", 1'b0, 1'b1, 0);
        tests_run++;
        if (phase !== '0) begin
            tests_failed++;
            $display("FAIL reset_phase: phase=%0d, need 0", phase);
        end
    endtask

    task automatic test_a4();
        drive_note(49, 3, "a4");
        tick();
        check_state("a4_fetch", 1'b0, 1'b0, 0);
        tick();
        check_load("a4");
        tests_run++;
        if (step_size !== 20'd38448) begin
            tests_failed++;
            $display("FAIL a4_const: step=%0d, need 38448", step_size);
        end
        repeat (3) sample_pulse(38448, "a4");
        beat_pulse();
        check_state("a4_beat1", 1'b1, 1'b0, 38448);
        beat_pulse();
        check_state("a4_beat2", 1'b1, 1'b0, GAP ? 0 : 38448);
        beat_pulse();
        check_state("a4_beat3", 1'b0, 1'b1, 0);
    endtask

    task automatic test_rest();
        drive_note(0, 2, "rest");
        repeat (2) tick();
        check_load("rest");
        repeat (2) sample_pulse(0, "rest");
        beat_pulse();
        check_state("rest_beat1", 1'b1, 1'b0, 0);
        beat_pulse();
        check_state("rest_beat2", 1'b0, 1'b1, 0);
    endtask

    task automatic test_dur0();
        bit seen_active = 1'b0;
        drive_note(5, 0, "dur0");
        for (int i = 0; i < 3 && note_done !== 1'b1; i++) begin
            tick();
            if (active === 1'b1) seen_active = 1'b1;
        end
        tests_run++;
        if (seen_active || note_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL dur0: seen_active=%b done=%b, need seen_active=0 done=1",
                     seen_active, note_done);
        end
    endtask

    task automatic test_pause();
        drive_note(49, 4, "pause");
        repeat (2) tick();
        check_load("pause");
        beat_pulse();
        play = 1'b0;
        tick();
        check_state("pause_hold", 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            beat_pulse();
            sample_pulse(0, "pause");
        end
        check_state("pause_end", 1'b1, 1'b0, 0);
        play = 1'b1;
        tick();
        check_state("pause_resume", 1'b1, 1'b0, 38448);
        sample_pulse(38448, "pause_resume");
        beat_pulse();
        check_state("pause_b2", 1'b1, 1'b0, 38448);
        beat_pulse();
        check_state("pause_b3", 1'b1, 1'b0, GAP ? 0 : 38448);
        beat_pulse();
        check_state("pause_b4", 1'b0, 1'b1, 0);
    endtask

    task automatic test_abort();
        drive_note(49, 4, "abort_a");
        repeat (2) tick();
        check_load("abort_a");
        beat_pulse();
        beat = 1'b1;
        drive_note(10, 2, "abort_b");
        beat = 1'b1;
        tick();
        beat = 1'b0;
        tick();
        check_load("abort_b");
        beat_pulse();
        check_state("abort_beat1", 1'b1, 1'b0, GAP ? 0 : rom_model(10));
        beat_pulse();
        check_state("abort_beat2", 1'b0, 1'b1, 0);
    endtask

    task automatic test_wrap_and_reset();
        logic [PHASE_W-1:0] prev;
        bit wrapped = 1'b0;
        drive_note(63, 60, "wrap");
        repeat (2) tick();
        check_load("wrap");
        for (int i = 0; i < 60; i++) begin
            prev = exp_phase;
            sample_pulse(rom_model(63), "wrap");
            if (exp_phase < prev) wrapped = 1'b1;
        end
        tests_run++;
        if (!wrapped) begin
            tests_failed++;
            $display("FAIL wrap_seen: model phase never wrapped");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_phase = '0;
        check_state("midreset", 1'b0, 1'b1, 0);
        tests_run++;
        if (phase !== '0) begin
            tests_failed++;
            $display("FAIL midreset_phase: phase=%0d, need 0", phase);
        end
    endtask

    initial begin
        test_reset();
        test_a4();
        test_rest();
        test_dur0();
        test_pause();
        test_abort();
        test_wrap_and_reset();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
